// File: rtl/truth_table_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer_pkg: shared sizes and FSM state type for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package truth_table_sequencer_pkg;

  localparam int N_IN           = 4;
  localparam int N_OUT          = 10;
  localparam int N_ROWS         = 16;
  localparam int SETTLE_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/truth_table_ram.sv
// ----------------------------------------------------------------------------
// truth_table_ram: 16x10 result table, one write port, combinational read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module truth_table_ram
  import truth_table_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [N_IN-1:0]  wr_addr,
  input  logic [N_OUT-1:0] wr_data,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data
);

  logic [N_OUT-1:0] mem_q [N_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ROWS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// truth_table_sequencer: steps a 4-bit code through 0..15, captures f_in per code
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] f_in,
  output logic [N_IN-1:0]  wxyz,
  output logic             busy,
  output logic             done,
  output logic             valid,
  input  logic [N_IN-1:0]  rd_addr,
  output logic [N_OUT-1:0] rd_data,
  output logic [N_OUT-1:0] sig
);

  localparam logic [N_IN-1:0] SETTLE_CNT = N_IN'(SETTLE);
  localparam logic [N_IN-1:0] LAST_CODE  = N_IN'(N_ROWS - 1);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  code_q,  code_d;
  logic [N_IN-1:0]  cnt_q,   cnt_d;
  logic [N_OUT-1:0] sig_q,   sig_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [N_IN-1:0]  wxyz_q,  wxyz_d;
  logic             row_we;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    valid_d = valid_q;
    row_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_DRIVE;
          code_d  = '0;
          cnt_d   = SETTLE_CNT;
          sig_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Abort suppresses the write of the row being captured
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          row_we = 1'b1;
          sig_d  = sig_q ^ f_in;
          if (code_q == LAST_CODE) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            code_d  = code_q + 1'b1;
            cnt_d   = SETTLE_CNT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs registered from the next state so they track state_q exactly
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
    wxyz_d = busy_d ? code_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wxyz_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wxyz_q  <= wxyz_d;
    end
  end

  truth_table_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (row_we),
    .wr_addr (code_q),
    .wr_data (f_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign wxyz  = wxyz_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign sig   = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// ----------------------------------------------------------------------------
// tb_truth_table_sequencer: random-keyed runs on SETTLE=3 and SETTLE=0 instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_truth_table_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;      // 0 selects the SETTLE=3 instance, 1 the SETTLE=0 one
  logic        start;
  logic        abort;
  logic [3:0]  rd_addr;
  logic [31:0] key;

  logic        start3, abort3, start0, abort0;
  logic [9:0]  f_in3, f_in0;
  logic [3:0]  wxyz3, wxyz0;
  logic        busy3, busy0, done3, done0, valid3, valid0;
  logic [9:0]  rd3, rd0, sig3, sig0;

  logic [3:0]  m_wxyz;
  logic        m_busy, m_done, m_valid;
  logic [9:0]  m_rd, m_sig;

  logic [9:0]  exp_tab [2][16];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Datapath under test: an arbitrary key-dependent function of the code
  function automatic logic [9:0] f_model(input logic [31:0] k, input logic [3:0] c);
    logic [9:0] m;
    logic [9:0] prod;
    m    = {6'd0, c} + 10'd1;
    prod = 10'(k[9:0] * m);
    return prod ^ (k[19:10] >> c[1:0]) ^ {c, c ^ k[23:20], c[1:0]};
  endfunction

  assign start3 = start & ~sel;
  assign abort3 = abort & ~sel;
  assign start0 = start & sel;
  assign abort0 = abort & sel;
  assign f_in3  = f_model(key, wxyz3);
  assign f_in0  = 10'h3FF;

  assign m_wxyz  = sel ? wxyz0  : wxyz3;
  assign m_busy  = sel ? busy0  : busy3;
  assign m_done  = sel ? done0  : done3;
  assign m_valid = sel ? valid0 : valid3;
  assign m_rd    = sel ? rd0    : rd3;
  assign m_sig   = sel ? sig0   : sig3;

  truth_table_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f_in(f_in3),
    .wxyz(wxyz3), .busy(busy3), .done(done3), .valid(valid3),
    .rd_addr(rd_addr), .rd_data(rd3), .sig(sig3)
  );

  truth_table_sequencer #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f_in0),
    .wxyz(wxyz0), .busy(busy0), .done(done0), .valid(valid0),
    .rd_addr(rd_addr), .rd_data(rd0), .sig(sig0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_addr = 4'(r);
      #1;
      check(tag, 32'(m_rd), 32'(exp_tab[int'(sel)][r]));
    end
  endtask

  // One run on the selected instance; k counts edges after the edge sampling start
  task automatic run_seq(input bit hold, input int abort_k, input int reset_k);
    int         p;
    int         s;
    logic [9:0] nv [16];
    logic [9:0] sig_exp;
    s = int'(sel);
    p = sel ? 2 : 5;
    key = $urandom;
    for (int c = 0; c < 16; c++) nv[c] = sel ? 10'h3FF : f_model(key, 4'(c));
    sig_exp = '0;
    start = 1'b1;
    for (int k = 0; k <= 16 * p + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && !hold) start = 1'b0;
      if (k >= p && k <= 16 * p && (k % p) == 0) begin
        exp_tab[s][k / p - 1] = nv[k / p - 1];
        sig_exp ^= nv[k / p - 1];
      end
      rd_addr = 4'($urandom);
      #1;
      check("rd_during_run", 32'(m_rd), 32'(exp_tab[s][rd_addr]));
      if (k == reset_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy",  32'(m_busy),  32'd0);
        check("rst_wxyz",  32'(m_wxyz),  32'd0);
        check("rst_done",  32'(m_done),  32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_sig",   32'(m_sig),   32'd0);
        for (int i = 0; i < 2; i++)
          for (int r = 0; r < 16; r++) exp_tab[i][r] = '0;
        check_rows("rst_row");
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == abort_k) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy",  32'(m_busy),  32'd0);
        check("abort_wxyz",  32'(m_wxyz),  32'd0);
        check("abort_done",  32'(m_done),  32'd0);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_sig",   32'(m_sig),   32'(sig_exp));
        repeat (3) begin
          @(posedge clk);
          #1;
          check("abort_idle", {30'd0, m_busy, m_done}, 32'd0);
        end
        check_rows("abort_row");
        return;
      end
      if (k < 16 * p) begin
        check("run_wxyz", 32'(m_wxyz), 32'(k / p));
        check("run_busy", 32'(m_busy), 32'd1);
        check("run_done", 32'(m_done), 32'd0);
        if (k == 0) begin
          check("start_valid_clr", 32'(m_valid), 32'd0);
          check("start_sig_clr",   32'(m_sig),   32'd0);
        end
      end else if (k == 16 * p) begin
        check("done_pulse", 32'(m_done), 32'd1);
        check("done_busy",  32'(m_busy), 32'd0);
        check("done_wxyz",  32'(m_wxyz), 32'd0);
        check("done_sig",   32'(m_sig),  32'(sig_exp));
      end else begin
        check("post_done", 32'(m_done),  32'd0);
        check("post_busy", 32'(m_busy),  32'd0);
        check("post_valid", 32'(m_valid), 32'd1);
      end
    end
    // A held start restarts on the very next edge, so rows are read only otherwise
    if (!hold) check_rows("row");
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    rd_addr = '0;
    key     = '0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 16; r++) exp_tab[i][r] = '0;

    #2;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check("reset_busy",  32'(m_busy),  32'd0);
      check("reset_done",  32'(m_done),  32'd0);
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_wxyz",  32'(m_wxyz),  32'd0);
      check("reset_sig",   32'(m_sig),   32'd0);
    end
    sel = 1'b0;
    check_rows("reset_row");
    @(negedge clk);
    rst_n = 1'b1;

    // start together with abort in IDLE must not launch a run
    start = 1'b1;
    abort = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("start_abort_busy", 32'(m_busy), 32'd0);
      check("start_abort_wxyz", 32'(m_wxyz), 32'd0);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    run_seq(1'b0, -1, -1);
    run_seq(1'b1, -1, -1);
    run_seq(1'b0, -1, -1);
    run_seq(1'b0, 7 * 5 + 4, -1);
    run_seq(1'b0, int'($urandom_range(1, 14)) * 5 + int'($urandom_range(0, 3)), -1);

    sel = 1'b1;
    run_seq(1'b0, -1, -1);
    run_seq(1'b0, int'($urandom_range(1, 14)) * 2, -1);
    run_seq(1'b0, -1, -1);

    sel = 1'b0;
    run_seq(1'b0, -1, 9 * 5 + 2);
    run_seq(1'b0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE, default 3, range 0..15: extra hold cycles per input code before capture.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  level-sampled run request; honoured only in IDLE.
REQ-005 abort  input  1  cancels a run in progress.
REQ-006 f_in  input  10  outputs f0..f9 of the 4-input logic datapath under test.
REQ-007 wxyz  output  4  input code driven to the datapath; bit3=w, bit2=x, bit1=y, bit0=z.
REQ-008 busy  output  1  high while a run is in progress (DRIVE or CAPTURE).
REQ-009 done  output  1  one-cycle pulse on run completion.
REQ-010 valid  output  1  high when the table holds a complete run since the last start.
REQ-011 rd_addr  input  4  table row select.
REQ-012 rd_data  output  10  combinational read of table row rd_addr.
REQ-013 sig  output  10  XOR of all f_in values captured since the last start.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, CAPTURE and DONE.
REQ-015 IDLE: start=1 and abort=0 -> DRIVE; code=0; cnt=SETTLE; sig cleared; valid cleared.
REQ-016 DRIVE: cnt==0 -> CAPTURE, else cnt decrements; DRIVE lasts SETTLE+1 cycles.
REQ-017 CAPTURE (1 cycle): at its closing edge, row[code]=f_in and sig^=f_in; code==15 -> DONE, else code+1, cnt=SETTLE, -> DRIVE.
REQ-018 DONE (1 cycle): done=1, valid set, -> IDLE.
REQ-019 wxyz SHALL equal code in DRIVE and CAPTURE, and SHALL be 0 in IDLE and DONE.
REQ-020 Per-code period SHALL be SETTLE+2 cycles; done SHALL be high in the cycle after rising edge 16*(SETTLE+2) counted from the edge that samples start.
REQ-021 code SHALL NOT wrap: after row 15 is captured no further row is written.
REQ-022 start SHALL be ignored while busy or in DONE; no queuing.
REQ-023 abort=1 in DRIVE or CAPTURE -> IDLE at the next edge, no write that edge, no done pulse, valid stays 0; rows already written are retained.
REQ-024 abort and start together in IDLE -> stay IDLE (abort wins).
REQ-025 rd_data SHALL reflect row writes from the edge after the write; reads during a run return current contents.
REQ-026 busy SHALL be a decode of state (DRIVE or CAPTURE) with no extra latency.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, code=0, cnt=0, wxyz=0, busy=0, done=0, valid=0, sig=0, and all 16 rows to 0.
REQ-028 Reset mid-run SHALL discard the run; operation SHALL resume on the first edge after deassertion, with the first start sampled as normal.

Structure
REQ-029 A shared package SHALL hold the state enum, N_IN=4, N_OUT=10, N_ROWS=16 and the SETTLE default.
REQ-030 The result table SHALL be one sub-module, truth_table_ram: 16x10 registers, one write port, combinational read, async clear.
REQ-031 Synthesisable RTL SHALL fit within 120-400 lines in total.

Verification
REQ-032 SETTLE=3, f_in driven by a model f=f(wxyz), start pulse -> 16 codes held for 5 cycles each; done 80 edges after start; rows 0..15 match the model; sig = XOR of the model rows; valid=1.
REQ-033 SETTLE=0, f_in=10'h3FF constant -> per-code period 2 cycles; done after 32 edges; sig=0 (an even count of identical rows).
REQ-034 abort asserted in CAPTURE of code 7 -> IDLE next cycle; rows 0..6 written, row 7 unchanged; no done; valid=0; wxyz=0.
REQ-035 start held high throughout the run -> exactly one run, no restart until IDLE; a second start after done begins a fresh run and clears valid and sig.
REQ-036 rst_n pulsed low mid-run (code 9) -> all outputs and rows read 0 immediately, without waiting for a clock edge.
REQ-037 start=1 and abort=1 together in IDLE -> busy stays 0; wxyz stays 0.
